// File: rtl/mem_to_axil.sv
// mem_to_axil: bridges a simple word-addressed memory request port onto a
// single-beat AXI4-Lite master. The response timeout is built only when the
// macro MEM_TO_AXIL_TIMEOUT_EN is defined; otherwise every wait is unbounded.
//
// Bus packing (MSB first):
//   m_axil_bus_o = {awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
//                   araddr, arprot, arvalid, rready}                 (111 bits)
//   m_axil_bus_i = {awready, wready, bresp, bvalid, arready, rdata, rresp,
//                   rvalid}                                          (41 bits)

`ifndef BSG_AXIL_MOSI_BUS_WIDTH
`define BSG_AXIL_MOSI_BUS_WIDTH(mask_p) (111*(mask_p))
`endif
`ifndef BSG_AXIL_MISO_BUS_WIDTH
`define BSG_AXIL_MISO_BUS_WIDTH(mask_p) (41*(mask_p))
`endif

module mem_to_axil #(
  parameter int          mem_addr_width_p = 16,
  parameter logic [31:0] axil_base_addr_p = 32'h0000_0000,
  parameter int          timeout_p        = 1024
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  output logic [`BSG_AXIL_MOSI_BUS_WIDTH(1)-1:0]  m_axil_bus_o,
  input  logic [`BSG_AXIL_MISO_BUS_WIDTH(1)-1:0]  m_axil_bus_i,
  input  logic [mem_addr_width_p-1:0]             addr_i,
  input  logic [31:0]                             data_i,
  input  logic                                    wen_i,
  input  logic                                    ren_i,
  output logic                                    ready_o,
  output logic [31:0]                             data_o,
  output logic                                    done_o,
  output logic                                    err_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_RESP,
    DONE
  } state_e;

  state_e state_q, state_n;

  logic [mem_addr_width_p-1:0] addr_q;
  logic [31:0]                 wdata_q;
  logic [31:0]                 rdata_q;
  logic                        aw_pend_q;
  logic                        w_pend_q;
  logic                        err_q;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        aw_ok, w_ok;
  logic [31:0] axil_addr;
  logic        wait_state;
  logic        timeout_hit;

  assign {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid} = m_axil_bus_i;

  assign axil_addr  = {axil_base_addr_p[31:mem_addr_width_p], addr_q};
  assign wait_state = state_q inside {WR, WR_RESP, RD, RD_RESP};

  assign m_axil_bus_o = {axil_addr, 3'b000, awvalid, wdata_q, 4'hF, wvalid, bready,
                         axil_addr, 3'b000, arvalid, rready};

  assign data_o = rdata_q;
  assign err_o  = err_q;

`ifdef MEM_TO_AXIL_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = 32'(timeout_p - 1);

  logic [31:0] timer_q;

  assign timeout_hit = wait_state && (timer_q == TimeoutLast);

  // Count cycles spent in the current wait state, restarting on every state change.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      timer_q <= '0;
    end else if (!wait_state || (state_n != state_q)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_p ^ wait_state;
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state decode and handshake outputs; everything idles low by default.
  always_comb begin
    state_n = state_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    aw_ok   = 1'b0;
    w_ok    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (wen_i) begin
          state_n = WR;
        end else if (ren_i) begin
          state_n = RD;
        end
      end
      WR: begin
        awvalid = aw_pend_q;
        wvalid  = w_pend_q;
        aw_ok   = !aw_pend_q || awready;
        w_ok    = !w_pend_q || wready;
        if (aw_ok && w_ok) begin
          state_n = WR_RESP;
        end else if (timeout_hit) begin
          state_n = DONE;
        end
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid || timeout_hit) begin
          state_n = DONE;
        end
      end
      RD: begin
        arvalid = 1'b1;
        if (arready) begin
          state_n = RD_RESP;
        end else if (timeout_hit) begin
          state_n = DONE;
        end
      end
      RD_RESP: begin
        rready = 1'b1;
        if (rvalid || timeout_hit) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Request capture, per-channel write-valid tracking, and response latching.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wen_i || ren_i) begin
            addr_q    <= addr_i;
            wdata_q   <= data_i;
            err_q     <= 1'b0;
            aw_pend_q <= wen_i;
            w_pend_q  <= wen_i;
          end
        end
        WR: begin
          if (awready) begin
            aw_pend_q <= 1'b0;
          end
          if (wready) begin
            w_pend_q <= 1'b0;
          end
          if (state_n == DONE) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            err_q     <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            err_q <= (bresp != 2'b00);
          end else if (state_n == DONE) begin
            err_q <= 1'b1;
          end
        end
        RD: begin
          if (state_n == DONE) begin
            err_q   <= 1'b1;
            rdata_q <= 32'hdead_beef;
          end
        end
        RD_RESP: begin
          if (rvalid) begin
            rdata_q <= rdata;
            err_q   <= (rresp != 2'b00);
          end else if (state_n == DONE) begin
            err_q   <= 1'b1;
            rdata_q <= 32'hdead_beef;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_to_axil.sv
// tb_mem_to_axil: randomized self-checking bench for mem_to_axil. A
// behavioural AXI4-Lite slave with programmable per-channel wait states sits
// on the bus; expected addresses, data, error flags and completion latency
// are derived from the transaction description, not from the RTL.
// Timeout scenario only runs when MEM_TO_AXIL_TIMEOUT_EN is defined.

`timescale 1ns/1ps

`ifndef BSG_AXIL_MOSI_BUS_WIDTH
`define BSG_AXIL_MOSI_BUS_WIDTH(mask_p) (111*(mask_p))
`endif
`ifndef BSG_AXIL_MISO_BUS_WIDTH
`define BSG_AXIL_MISO_BUS_WIDTH(mask_p) (41*(mask_p))
`endif

module tb_mem_to_axil;

  localparam int          ADDR_W   = 12;
  localparam logic [31:0] BASE     = 32'h4321_7ABC;
  localparam int          TIMEOUT  = 8;
  localparam int          MAX_WAIT = 100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [`BSG_AXIL_MOSI_BUS_WIDTH(1)-1:0] mosi;
  logic [`BSG_AXIL_MISO_BUS_WIDTH(1)-1:0] miso;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wr_data;
  logic        wen, ren;
  logic        ready, done, err;
  logic [31:0] rd_data;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  mem_to_axil #(
    .mem_addr_width_p (ADDR_W),
    .axil_base_addr_p (BASE),
    .timeout_p        (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .m_axil_bus_o (mosi),
    .m_axil_bus_i (miso),
    .addr_i       (addr),
    .data_i       (wr_data),
    .wen_i        (wen),
    .ren_i        (ren),
    .ready_o      (ready),
    .data_o       (rd_data),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Master-side fields unpacked from the DUT's request bus.
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  assign {awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
          araddr, arprot, arvalid, rready} = mosi;

  // Slave configuration, set by the stimulus process between transactions.
  int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic        b_never = 1'b0, r_never = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  // Slave channel state.
  logic aw_done = 1'b0, w_done = 1'b0, ar_done = 1'b0;
  int   aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int   aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0]  cap_wstrb = 0;
  logic [2:0]  cap_awprot = 0, cap_arprot = 0;

  logic awready, wready, bvalid, arready, rvalid;

  // Slave ready/valid generation from the programmed wait counts.
  always_comb begin
    awready = (aw_lat == 0) || (awvalid && (aw_cnt >= aw_lat));
    wready  = (w_lat == 0)  || (wvalid && (w_cnt >= w_lat));
    bvalid  = aw_done && w_done && (b_cnt >= b_lat) && !b_never;
    arready = (ar_lat == 0) || (arvalid && (ar_cnt >= ar_lat));
    rvalid  = ar_done && (r_cnt >= r_lat) && !r_never;
    miso    = {awready, wready, (bvalid ? bresp_cfg : 2'b00), bvalid, arready,
               (rvalid ? rdata_cfg : 32'h0), (rvalid ? rresp_cfg : 2'b00), rvalid};
  end

  // Slave handshake bookkeeping and request capture.
  always @(posedge clk) begin
    if (!reset_n) begin
      aw_done <= 1'b0; w_done <= 1'b0; ar_done <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      if (awvalid && awready && !aw_done) begin
        aw_done <= 1'b1; aw_hs <= aw_hs + 1;
        cap_awaddr <= awaddr; cap_awprot <= awprot;
      end else if (awvalid && !awready) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready && !w_done) begin
        w_done <= 1'b1; w_hs <= w_hs + 1;
        cap_wdata <= wdata; cap_wstrb <= wstrb;
      end else if (wvalid && !wready) begin
        w_cnt <= w_cnt + 1;
      end
      if (bvalid && bready) begin
        aw_done <= 1'b0; w_done <= 1'b0;
        aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      end else if (aw_done && w_done) begin
        b_cnt <= b_cnt + 1;
      end
      if (arvalid && arready && !ar_done) begin
        ar_done <= 1'b1; ar_hs <= ar_hs + 1;
        cap_araddr <= araddr; cap_arprot <= arprot;
      end else if (arvalid && !arready) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (rvalid && rready) begin
        ar_done <= 1'b0; ar_cnt <= 0; r_cnt <= 0;
      end else if (ar_done) begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  // Protocol monitor: done pulses, valid activity and AXI rule violations.
  int   done_cnt = 0, aw_cyc = 0, w_cyc = 0, ar_cyc = 0, viol = 0;
  logic prev_aw = 1'b0, prev_w = 1'b0, prev_ar = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (done)    done_cnt <= done_cnt + 1;
      if (awvalid) aw_cyc <= aw_cyc + 1;
      if (wvalid)  w_cyc <= w_cyc + 1;
      if (arvalid) ar_cyc <= ar_cyc + 1;
      if ((awvalid && aw_done) || (wvalid && w_done) || (arvalid && ar_done) ||
          (bready && !(aw_done && w_done)) || (rready && !ar_done) ||
          (prev_aw && !awvalid) || (prev_w && !wvalid) || (prev_ar && !arvalid))
        viol <= viol + 1;
      prev_aw <= awvalid && !awready;
      prev_w  <= wvalid && !wready;
      prev_ar <= arvalid && !arready;
    end else begin
      prev_aw <= 1'b0; prev_w <= 1'b0; prev_ar <= 1'b0;
    end
  end

  logic [31:0] model_rdata = 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request, then wait (bounded) for the completion pulse.
  task automatic applyStimulus(input logic do_wr, input logic do_rd,
                               input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               output int lat, output int busy_ready, output logic timed_out);
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    wen = do_wr; ren = do_rd; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0;
    addr = ADDR_W'($urandom); wr_data = $urandom;
    lat = 0; busy_ready = 0; timed_out = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (ready) busy_ready++;
      if (lat >= MAX_WAIT) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  // Run one transaction and compare everything observable with the model.
  task automatic runTxn(input string tag, input logic do_wr, input logic do_rd,
                        input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input logic expect_timeout);
    int lat, busy, done0, aw0, w0, ar0, viol0, awh0, wh0, arh0, exp_lat;
    logic timed_out, is_wr, exp_err;
    logic [31:0] exp_addr;
    done0 = done_cnt; aw0 = aw_cyc; w0 = w_cyc; ar0 = ar_cyc; viol0 = viol;
    awh0 = aw_hs; wh0 = w_hs; arh0 = ar_hs;
    is_wr    = do_wr;
    exp_addr = (BASE & ~((32'h1 << ADDR_W) - 32'h1)) | 32'(a);
    if (expect_timeout) begin
      exp_lat     = 2 + ar_lat + TIMEOUT;
      exp_err     = 1'b1;
      model_rdata = 32'hDEAD_BEEF;
    end else if (is_wr) begin
      exp_lat = 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat;
      exp_err = (bresp_cfg != 2'b00);
    end else begin
      exp_lat     = 3 + ar_lat + r_lat;
      exp_err     = (rresp_cfg != 2'b00);
      model_rdata = rdata_cfg;
    end
    applyStimulus(do_wr, do_rd, a, d, lat, busy, timed_out);
    checkOutput({tag, ".completed"}, 32'(timed_out), 32'd0);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, ".ready_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, ".data_o"}, rd_data, model_rdata);
    @(negedge clk);
    checkOutput({tag, ".done_pulses"}, 32'(done_cnt - done0), 32'd1);
    checkOutput({tag, ".ready_after"}, 32'(ready), 32'd1);
    checkOutput({tag, ".violations"}, 32'(viol - viol0), 32'd0);
    if (is_wr) begin
      checkOutput({tag, ".awaddr"}, cap_awaddr, exp_addr);
      checkOutput({tag, ".wdata"}, cap_wdata, d);
      checkOutput({tag, ".wstrb"}, 32'(cap_wstrb), 32'hF);
      checkOutput({tag, ".awprot"}, 32'(cap_awprot), 32'd0);
      checkOutput({tag, ".aw_w_hs"}, 32'((aw_hs - awh0) + (w_hs - wh0)), 32'd2);
      checkOutput({tag, ".ar_idle"}, 32'(ar_cyc - ar0), 32'd0);
    end else begin
      checkOutput({tag, ".araddr"}, cap_araddr, exp_addr);
      checkOutput({tag, ".arprot"}, 32'(cap_arprot), 32'd0);
      checkOutput({tag, ".ar_hs"}, 32'(ar_hs - arh0), 32'd1);
      checkOutput({tag, ".aw_w_idle"}, 32'((aw_cyc - aw0) + (w_cyc - w0)), 32'd0);
    end
  endtask

  task automatic setLat(input int aw, input int w, input int b, input int ar, input int r);
    aw_lat = aw; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".ready"}, 32'(ready), 32'd1);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
    checkOutput({tag, ".err"}, 32'(err), 32'd0);
    checkOutput({tag, ".data_o"}, rd_data, 32'd0);
    checkOutput({tag, ".handshakes"}, {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
  endtask

  // Watchdog so the bench always ends even if the DUT wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int guard, done0;
    reset_n = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checkIdleOutputs("post_reset");

    setLat(0, 0, 0, 0, 0);
    runTxn("wr_zero_wait", 1'b1, 1'b0, 12'h010, 32'hCAFE_F00D, 1'b0);

    setLat(0, 0, 0, 0, 5);
    rdata_cfg = 32'h1234_5678;
    runTxn("rd_slow", 1'b0, 1'b1, 12'h3A4, 32'h0, 1'b0);

    setLat(0, 3, 0, 0, 0);
    runTxn("wr_w_stall", 1'b1, 1'b0, 12'hFFF, 32'h0BAD_F00D, 1'b0);

    setLat(1, 0, 2, 0, 0);
    runTxn("wr_rd_both", 1'b1, 1'b1, 12'h000, 32'h5555_AAAA, 1'b0);

    setLat(0, 0, 0, 0, 0);
    bresp_cfg = 2'b10;
    runTxn("wr_slverr", 1'b1, 1'b0, 12'h044, 32'h0000_0001, 1'b0);
    bresp_cfg = 2'b00;

    for (int i = 0; i < 24; i++) begin
      logic wr_b, rd_b;
      wr_b = 1'($urandom);
      rd_b = wr_b ? 1'($urandom) : 1'b1;
      setLat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdata_cfg = $urandom;
      runTxn($sformatf("rand%0d", i), wr_b, rd_b, ADDR_W'($urandom), $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    setLat(0, 0, 0, 0, 0);
    b_never = 1'b1;
    done0 = done_cnt;
    @(negedge clk);
    wen = 1'b1; addr = 12'h123; wr_data = 32'h7777_7777;
    @(posedge clk); #1 wen = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!bready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("abort.in_wr_resp", 32'(bready), 32'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    b_never = 1'b0;
    model_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("abort.no_done", 32'(done_cnt - done0), 32'd0);
    checkIdleOutputs("abort");

    setLat(0, 0, 0, 2, 1);
    rdata_cfg = 32'hA5A5_0F0F;
    runTxn("rd_after_abort", 1'b0, 1'b1, 12'h800, 32'h0, 1'b0);

`ifdef MEM_TO_AXIL_TIMEOUT_EN
    setLat(0, 0, 0, 0, 0);
    r_never = 1'b1;
    runTxn("rd_timeout", 1'b0, 1'b1, 12'h0F0, 32'h0, 1'b1);
    r_never = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
